mux2to1_rr_arbiter: RTL

//  Upstream control stage for mux2to1. Arbitrates two valid/ready sources

---
 rtl/mux2to1_rr_arbiter_pkg.sv | 17 +
 rtl/mux2to1_out_reg.sv | 34 +++
 rtl/mux2to1_rr_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mux2to1_rr_arbiter_pkg.sv
// Shared types and constants for the mux2to1 round-robin arbiter.
package mux2to1_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } state_t;

  localparam int unsigned STAT_W = 16;

  // Grant state of the opposite source.
  function automatic state_t swap_grant(input state_t s);
    return (s == ST_G1) ? ST_G0 : ST_G1;
  endfunction

endpackage

// File: rtl/mux2to1_out_reg.sv
// Single-entry valid/ready output register; owns the accept enable.
module mux2to1_out_reg #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready_c,
  output logic              accept_c,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  // The slot can take a new beat when empty or drained this cycle.
  always_comb begin
    load_ready_c = ~out_valid | out_ready;
    accept_c     = load_valid & load_ready_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept_c) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mux2to1_rr_arbiter.sv
// Round-robin, burst-bounded arbiter driving the mux2to1 select line.
// Define MUX_ARB_STATS_EN to add per-source accepted-beat counters cnt0/cnt1.
module mux2to1_rr_arbiter
  import mux2to1_rr_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  output logic              in1_ready,
  output logic              sel,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
`ifdef MUX_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] cnt0,
  output logic [STAT_W-1:0] cnt1
`endif
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;

  state_t             state;
  logic [CNT_W-1:0]   beat_cnt;
  logic               last;
  logic               grant_valid;
  logic               other_valid;
  logic               gid;
  logic               burst_end;
  logic               load_ready_c;
  logic               accept_c;
  logic [DATA_W-1:0]  grant_data;

  // Granted-side handshake; sel equals the grant index in G0/G1.
  always_comb begin
    grant_valid = 1'b0;
    other_valid = 1'b0;
    gid         = 1'b0;
    in0_ready   = 1'b0;
    in1_ready   = 1'b0;
    case (state)
      ST_G0: begin
        grant_valid = in0_valid;
        other_valid = in1_valid;
        in0_ready   = load_ready_c;
      end
      ST_G1: begin
        grant_valid = in1_valid;
        other_valid = in0_valid;
        gid         = 1'b1;
        in1_ready   = load_ready_c;
      end
      default: ;
    endcase
    grant_data = sel ? in1_data : in0_data;
    burst_end  = (beat_cnt == CNT_W'(MAX_BURST - 1));
  end

  mux2to1_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_valid   (grant_valid),
    .load_data    (grant_data),
    .load_ready_c (load_ready_c),
    .accept_c     (accept_c),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      sel      <= 1'b0;
      beat_cnt <= '0;
      last     <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          // Ties go to the side that did not release last.
          if (in0_valid && (!in1_valid || last)) begin
            state <= ST_G0;
            sel   <= 1'b0;
          end else if (in1_valid) begin
            state <= ST_G1;
            sel   <= 1'b1;
          end
        end
        ST_G0, ST_G1: begin
          if (!grant_valid) begin
            last     <= gid;
            beat_cnt <= '0;
            if (other_valid) begin
              state <= swap_grant(state);
              sel   <= ~gid;
            end else begin
              state <= ST_IDLE;
            end
          end else if (accept_c) begin
            if (burst_end) begin
              beat_cnt <= '0;
              if (other_valid) begin
                last  <= gid;
                state <= swap_grant(state);
                sel   <= ~gid;
              end
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MUX_ARB_STATS_EN
  logic acc0;
  logic acc1;

  always_comb begin
    acc0 = in0_valid & in0_ready;
    acc1 = in1_valid & in1_ready;
  end

  // Saturating per-source accepted-beat counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (acc0 && (cnt0 != '1)) cnt0 <= cnt0 + STAT_W'(1);
      if (acc1 && (cnt1 != '1)) cnt1 <= cnt1 + STAT_W'(1);
    end
  end
`endif

endmodule
